// File: rtl/cache_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module    : cache_mem_arbiter_if
// Purpose   : Client request/response bus plus line-wide RAM port of the
//             cache/RAM arbiter.
// Revision  : 1.0 - initial release
// ============================================================================
interface cache_mem_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 32,
  parameter int LINE_W = 256
);
  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH-1:0]        req_write;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH*LINE_W-1:0] req_wdata;
  logic [NUM_CH-1:0]        resp_valid;
  logic [NUM_CH-1:0]        resp_err;
  logic [LINE_W-1:0]        resp_rdata;
  logic                     busy;
  logic                     enable_cache_to_ram;
  logic                     write_cache_to_ram;
  logic [ADDR_W-1:0]        address_cache_to_ram;
  logic [LINE_W-1:0]        data_cache_to_ram_o;
  logic                     response_ram_to_cache;
  logic [LINE_W-1:0]        data_ram_to_cache_i;

  // Arbiter side.
  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    input  response_ram_to_cache, data_ram_to_cache_i,
    output resp_valid, resp_err, resp_rdata, busy,
    output enable_cache_to_ram, write_cache_to_ram,
    output address_cache_to_ram, data_cache_to_ram_o
  );

  // Environment side: cache clients together with the RAM.
  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    output response_ram_to_cache, data_ram_to_cache_i,
    input  resp_valid, resp_err, resp_rdata, busy,
    input  enable_cache_to_ram, write_cache_to_ram,
    input  address_cache_to_ram, data_cache_to_ram_o
  );
endinterface
`default_nettype wire

// File: rtl/cache_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module    : cache_mem_arbiter
// Purpose   : Round-robin N-channel arbiter sharing one line-wide RAM port,
//             one latched transaction at a time.
// Build opt : MEM_TIMEOUT_EN - adds a RAM response timeout with error pulse.
// Revision  : 1.0 - initial release
// ============================================================================
module cache_mem_arbiter #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 32,
  parameter int LINE_W      = 256,
  parameter int TIMEOUT_CYC = 1024
) (
  input logic                clk,
  input logic                rst,
  cache_mem_arbiter_if.slave bus
);
  localparam int GNT_W = $clog2(NUM_CH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [GNT_W-1:0]  r_grant;
  logic [GNT_W-1:0]  r_ptr;
  logic [GNT_W-1:0]  w_pick;
  logic [GNT_W-1:0]  w_cand;
  logic              w_found;
  logic              w_sel_write;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [LINE_W-1:0] w_sel_wdata;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic [LINE_W-1:0] r_rdata;
  logic              w_timeout;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYC));
`else
  logic [31:0] w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = 32'(TIMEOUT_CYC);
  assign w_timeout            = 1'b0;
`endif

  // Search starts one past the last grant, so the previous winner goes last.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      w_cand = GNT_W'((int'(r_ptr) + i) % NUM_CH);
      if (!w_found && bus.req_valid[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  always_comb begin
    w_sel_write = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (w_pick == GNT_W'(i)) begin
        w_sel_write = bus.req_write[i];
        w_sel_addr  = bus.req_addr[i*ADDR_W +: ADDR_W];
        w_sel_wdata = bus.req_wdata[i*LINE_W +: LINE_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_ISSUE;
      S_ISSUE: if (bus.response_ram_to_cache || w_timeout) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_grant <= '0;
      r_ptr   <= GNT_W'(NUM_CH - 1);
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
`ifdef MEM_TIMEOUT_EN
      r_cnt   <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_grant <= w_pick;
            r_ptr   <= w_pick;
            r_write <= w_sel_write;
            r_addr  <= w_sel_addr;
            r_wdata <= w_sel_wdata;
`ifdef MEM_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        S_ISSUE: begin
          // A real response beats a timeout landing in the same cycle.
          if (bus.response_ram_to_cache) begin
            r_rdata <= r_write ? '0 : bus.data_ram_to_cache_i;
`ifdef MEM_TIMEOUT_EN
            r_err   <= 1'b0;
          end else if (w_timeout) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
`endif
          end
`ifdef MEM_TIMEOUT_EN
          r_cnt <= r_cnt + 1'b1;
`endif
        end
        S_RESP: begin
          r_rdata <= '0;
`ifdef MEM_TIMEOUT_EN
          r_err   <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.resp_valid           = '0;
    bus.resp_err             = '0;
    bus.resp_rdata           = '0;
    bus.busy                 = (r_state != S_IDLE);
    bus.enable_cache_to_ram  = (r_state == S_ISSUE);
    bus.write_cache_to_ram   = r_write;
    bus.address_cache_to_ram = r_addr;
    bus.data_cache_to_ram_o  = r_wdata;
    if (r_state == S_RESP) begin
      bus.resp_valid[r_grant] = 1'b1;
      bus.resp_rdata          = r_rdata;
`ifdef MEM_TIMEOUT_EN
      bus.resp_err[r_grant]   = r_err;
`endif
    end
  end
endmodule
`default_nettype wire
